sd_cmd_sequencer: RTL and testbench
===================================

SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- TIMEOUT_VAL, 32'h0000_777F, value written to controller timeout register at init.
- CLK_DIV, 32'h0000_0001, value written to controller clock-divider register at init.
- POLL_LIMIT, 1024, maximum status reads per command before timeout error.
REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
- wb_clk_i, in, 1, clock.
- wb_rst_i, in, 1, reset; asynchronous, active-high.
- req_i, in, 1, start a command.
- req_cmd_i, in, 16, command-setting word.
- req_arg_i, in, 32, command argument.
- busy_o, out, 1, sequencer not idle.
- done_o, out, 1, one-cycle completion pulse.
- err_o, out, 1, completion had an error (valid with done_o).
- resp_o, out, 32, response word, or error status on error.
- m_wb_adr_o, out, 8, register address to SD controller slave.
- m_wb_dat_o, out, 32, write data.
- m_wb_dat_i, in, 32, read data.
- m_wb_sel_o, out, 4, byte select, constant 4'hF.
- m_wb_we_o, out, 1, write enable.
- m_wb_cyc_o, out, 1, cycle.
- m_wb_stb_o, out, 1, strobe.
- m_wb_ack_i, in, 1, acknowledge.

Function
REQ-003 Controller register map: 0x00 argument (write starts command), 0x04 command setting, 0x0C response, 0x2C timeout, 0x34 normal interrupt status (bit0 command complete, bit15 error summary), 0x38 error interrupt status, 0x4C clock divider.
REQ-004 Bus transfers are single classic-cycle: cyc and stb asserted together with stable adr/dat/we until the first cycle m_wb_ack_i=1, then both deasserted for at least one cycle before the next transfer.
REQ-005 m_wb_ack_i is ignored while m_wb_stb_o=0.
REQ-006 States: INIT_TO, INIT_DIV, IDLE, WR_CMD, WR_ARG, POLL, RD_RESP, RD_ERR, CLR, DONE.
REQ-007 After reset the block writes TIMEOUT_VAL to 0x2C (INIT_TO), then CLK_DIV to 0x4C (INIT_DIV), then enters IDLE; busy_o=1 throughout init.
REQ-008 In IDLE with req_i=1, the block latches req_cmd_i (zero-extended to 32 bits) and req_arg_i, and enters WR_CMD; req_i during init or non-IDLE states is ignored and not queued.
REQ-009 WR_CMD writes the latched command to 0x04, then WR_ARG writes the latched argument to 0x00, then the block enters POLL.
REQ-010 POLL reads 0x34 and takes these branches:
- bit15=1 -> RD_ERR (takes priority over bit0).
- bit0=1 -> RD_RESP.
- else -> reread, incrementing an 11-bit-minimum poll counter.
REQ-011 When the poll counter reaches POLL_LIMIT reads with neither bit set, the block sets err_o, sets resp_o=32'hFFFF_FFFF, and enters CLR.
REQ-012 RD_RESP reads 0x0C into resp_o with err_o=0, then enters CLR; RD_ERR reads 0x38 into resp_o with err_o=1, then enters CLR.
REQ-013 CLR writes 32'h0 to 0x34; DONE asserts done_o for exactly one cycle, then returns to IDLE.
REQ-014 busy_o=0 only in IDLE.
REQ-015 resp_o and err_o hold their values until the next command's completion.
REQ-016 The poll counter clears on entry to WR_CMD.

Reset
REQ-017 Reset asserted at any time, including mid-transfer, immediately drives the following and re-runs the init sequence after release:
- m_wb_cyc_o=0, m_wb_stb_o=0, m_wb_we_o=0.
- m_wb_adr_o=0, m_wb_dat_o=0.
- done_o=0, err_o=0, resp_o=0.
- busy_o=1, state=INIT_TO.

Verification
REQ-018 Release reset, slave acks each transfer after 2 cycles -> write 0x2C=0x777F, then write 0x4C=0x1, then busy_o=0.
REQ-019 In IDLE, req_i with cmd 0x031A and arg 0xF0F0F0F0; status reads return 0, 0, then 0x1; 0x0C returns 0x12345678 -> the following occur in order:
- write 0x04=0x031A, then write 0x00=0xF0F0F0F0.
- three reads of 0x34, then a read of 0x0C.
- write 0x34=0.
- done_o pulse with resp_o=0x12345678, err_o=0.
REQ-020 Status returns 0x8001 and 0x38 returns 0x0004 -> resp_o=0x4, err_o=1, no read of 0x0C.
REQ-021 Status always 0 with POLL_LIMIT=4 -> exactly 4 status reads, then write 0x34=0, then done_o with err_o=1 and resp_o=0xFFFFFFFF.
REQ-022 Reset asserted while stb is waiting for ack during POLL -> cyc/stb low in the same cycle; after release the timeout write is the first transfer.
REQ-023 req_i pulsed while busy_o=1 -> no additional command sequence is issued.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// Sequences one SD command at a time over a Wishbone master port: controller init,
// command/argument writes, status polling, response or error readback and status clear.
module sd_cmd_sequencer #(
    parameter logic [31:0] TIMEOUT_VAL = 32'h0000_777F,
    parameter logic [31:0] CLK_DIV     = 32'h0000_0001,
    parameter int          POLL_LIMIT  = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_i,
    input  logic [15:0] req_cmd_i,
    input  logic [31:0] req_arg_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] resp_o,
    output logic [7:0]  m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    input  logic [31:0] m_wb_dat_i,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i
);

    localparam int PCW = ($clog2(POLL_LIMIT + 1) > 11) ? $clog2(POLL_LIMIT + 1) : 11;
    localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);

    localparam logic [7:0] ADR_ARG  = 8'h00;
    localparam logic [7:0] ADR_CMD  = 8'h04;
    localparam logic [7:0] ADR_RESP = 8'h0C;
    localparam logic [7:0] ADR_TO   = 8'h2C;
    localparam logic [7:0] ADR_NIS  = 8'h34;
    localparam logic [7:0] ADR_EIS  = 8'h38;
    localparam logic [7:0] ADR_DIV  = 8'h4C;

    typedef enum logic [3:0] {
        INIT_TO, INIT_DIV, IDLE, WR_CMD, WR_ARG, POLL, RD_RESP, RD_ERR, CLR, DONE
    } state_t;

    state_t          state_q, state_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [7:0]      adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     cmd_q, cmd_d;
    logic [31:0]     arg_q, arg_d;
    logic [PCW-1:0]  cnt_q, cnt_d;
    logic [31:0]     resp_q, resp_d;
    logic            err_q, err_d;

    logic            x_we;
    logic [7:0]      x_adr;
    logic [31:0]     x_dat;
    logic            xfer_ack;
    logic [PCW-1:0]  cnt_inc;

    // Transfer each bus state performs; reads carry zero write data.
    always_comb begin
        x_we  = 1'b0;
        x_adr = 8'h00;
        x_dat = 32'h0;
        case (state_q)
            INIT_TO:  begin x_we = 1'b1; x_adr = ADR_TO;  x_dat = TIMEOUT_VAL; end
            INIT_DIV: begin x_we = 1'b1; x_adr = ADR_DIV; x_dat = CLK_DIV;     end
            WR_CMD:   begin x_we = 1'b1; x_adr = ADR_CMD; x_dat = cmd_q;       end
            WR_ARG:   begin x_we = 1'b1; x_adr = ADR_ARG; x_dat = arg_q;       end
            POLL:     x_adr = ADR_NIS;
            RD_RESP:  x_adr = ADR_RESP;
            RD_ERR:   x_adr = ADR_EIS;
            CLR:      begin x_we = 1'b1; x_adr = ADR_NIS; x_dat = 32'h0;       end
            default:  ;
        endcase
    end

    assign xfer_ack = stb_q & m_wb_ack_i;
    assign cnt_inc  = cnt_q + PCW'(1);

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    cmd_d   = {16'h0, req_cmd_i};
                    arg_d   = req_arg_i;
                    cnt_d   = '0;
                    state_d = WR_CMD;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                // Strobe is only raised from a low cycle, which gives the idle gap between transfers.
                if (!stb_q) begin
                    stb_d = 1'b1;
                    we_d  = x_we;
                    adr_d = x_adr;
                    dat_d = x_dat;
                end else if (xfer_ack) begin
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    case (state_q)
                        INIT_TO:  state_d = INIT_DIV;
                        INIT_DIV: state_d = IDLE;
                        WR_CMD:   state_d = WR_ARG;
                        WR_ARG:   state_d = POLL;
                        POLL: begin
                            if (m_wb_dat_i[15]) begin
                                state_d = RD_ERR;
                            end else if (m_wb_dat_i[0]) begin
                                state_d = RD_RESP;
                            end else if (cnt_inc == POLL_MAX) begin
                                cnt_d   = cnt_inc;
                                err_d   = 1'b1;
                                resp_d  = 32'hFFFF_FFFF;
                                state_d = CLR;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                        RD_RESP: begin resp_d = m_wb_dat_i; err_d = 1'b0; state_d = CLR; end
                        RD_ERR:  begin resp_d = m_wb_dat_i; err_d = 1'b1; state_d = CLR; end
                        CLR:     state_d = DONE;
                        default: state_d = INIT_TO;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= INIT_TO;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 8'h00;
            dat_q   <= 32'h0;
            cmd_q   <= 32'h0;
            arg_q   <= 32'h0;
            cnt_q   <= '0;
            resp_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign m_wb_cyc_o = stb_q;
    assign m_wb_stb_o = stb_q;
    assign m_wb_we_o  = we_q;
    assign m_wb_adr_o = adr_q;
    assign m_wb_dat_o = dat_q;
    assign m_wb_sel_o = 4'hF;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign err_o      = err_q;
    assign resp_o     = resp_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: Wishbone slave model with 2-cycle ack, transaction log,
// table of command scenarios, plus init, busy-request and mid-transfer reset sequences.
module tb_sd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] cmd = 16'h0;
    logic [31:0] arg = 32'h0;
    logic        busy_o, done_o, err_o;
    logic [31:0] resp_o;
    logic [7:0]  m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic [31:0] s_dat = 32'h0;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
    logic        s_ack = 1'b0;

    always #5 clk = ~clk;

    sd_cmd_sequencer #(.POLL_LIMIT(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_i      (req),
        .req_cmd_i  (cmd),
        .req_arg_i  (arg),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .resp_o     (resp_o),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_dat_i (s_dat),
        .m_wb_sel_o (m_wb_sel_o),
        .m_wb_we_o  (m_wb_we_o),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_ack_i (s_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave model: log entries are {we, adr, data}, data = write data or returned read data.
    logic [31:0] st_q[$];
    logic [31:0] r0c = 32'h0;
    logic [31:0] r38 = 32'h0;
    logic [40:0] log_q[$];
    int          wcnt = 0;
    int          proto_err = 0;
    logic        prev_stb = 1'b0;
    logic [40:0] prev_bus = '0;
    logic [31:0] rd;

    initial forever begin
        @(posedge clk); #1;
        if (rst) begin
            s_ack = 1'b0; wcnt = 0; prev_stb = 1'b0;
        end else begin
            if (m_wb_cyc_o !== m_wb_stb_o) proto_err++;
            if (m_wb_stb_o && m_wb_sel_o !== 4'hF) proto_err++;
            if (s_ack) begin
                if (m_wb_stb_o) proto_err++;
                s_ack = 1'b0;
                wcnt  = 0;
            end else if (m_wb_stb_o) begin
                if (prev_stb && {m_wb_we_o, m_wb_adr_o, m_wb_dat_o} !== prev_bus) proto_err++;
                wcnt++;
                if (wcnt == 2) begin
                    if (m_wb_we_o) begin
                        log_q.push_back({1'b1, m_wb_adr_o, m_wb_dat_o});
                        s_dat = 32'h0;
                    end else begin
                        case (m_wb_adr_o)
                            8'h34:   rd = (st_q.size() > 0) ? st_q.pop_front() : 32'h0;
                            8'h0C:   rd = r0c;
                            8'h38:   rd = r38;
                            default: rd = 32'hBAD0_BAD0;
                        endcase
                        s_dat = rd;
                        log_q.push_back({1'b0, m_wb_adr_o, rd});
                    end
                    s_ack = 1'b1;
                end
            end else begin
                wcnt = 0;
            end
            prev_stb = m_wb_stb_o;
            prev_bus = {m_wb_we_o, m_wb_adr_o, m_wb_dat_o};
        end
    end

    int          done_cnt = 0;
    logic        d_err = 1'b0;
    logic [31:0] d_resp = 32'h0;

    initial forever begin
        @(posedge clk); #1;
        if (done_o) begin
            done_cnt++;
            d_err  = err_o;
            d_resp = resp_o;
        end
    end

    // kind: 0 = response read, 1 = error-status read, 2 = poll timeout
    typedef struct {
        logic [15:0]       cmd;
        logic [31:0]       arg;
        logic [3:0][31:0]  st;
        int                nst;
        int                polls;
        logic [31:0]       r0c;
        logic [31:0]       r38;
        int                kind;
        logic              exp_err;
        logic [31:0]       exp_resp;
    } vec_t;

    vec_t        vec [6];
    logic [40:0] exp_q[$];
    logic [40:0] got;
    int          dstart;
    bit          found;

    initial begin
        vec[0] = '{cmd:16'h031A, arg:32'hF0F0_F0F0, st:{32'h0, 32'h1, 32'h0, 32'h0}, nst:3, polls:3,
                   r0c:32'h1234_5678, r38:32'hDEAD_0000, kind:0, exp_err:1'b0, exp_resp:32'h1234_5678};
        vec[1] = '{cmd:16'h0011, arg:32'h0000_0001, st:{32'h0, 32'h0, 32'h0, 32'h8001}, nst:1, polls:1,
                   r0c:32'h1111_1111, r38:32'h0000_0004, kind:1, exp_err:1'b1, exp_resp:32'h0000_0004};
        vec[2] = '{cmd:16'hFFFF, arg:32'h89AB_CDEF, st:{32'h1, 32'h0, 32'h0, 32'h0}, nst:4, polls:4,
                   r0c:32'hA5A5_A5A5, r38:32'h0, kind:0, exp_err:1'b0, exp_resp:32'hA5A5_A5A5};
        vec[3] = '{cmd:16'h0005, arg:32'h0000_0005, st:{32'h0, 32'h0, 32'h0, 32'h8000}, nst:1, polls:1,
                   r0c:32'h2222_2222, r38:32'h0000_0010, kind:1, exp_err:1'b1, exp_resp:32'h0000_0010};
        vec[4] = '{cmd:16'h0007, arg:32'h0000_0007, st:{32'h0, 32'h0, 32'h3, 32'h7FFE}, nst:2, polls:2,
                   r0c:32'hCAFE_F00D, r38:32'h3333_3333, kind:0, exp_err:1'b0, exp_resp:32'hCAFE_F00D};
        vec[5] = '{cmd:16'h0022, arg:32'h0000_0000, st:{32'h0, 32'h0, 32'h0, 32'h0}, nst:0, polls:4,
                   r0c:32'h4444_4444, r38:32'h5555_5555, kind:2, exp_err:1'b1, exp_resp:32'hFFFF_FFFF};

        // Reset state
        repeat (3) @(posedge clk); #2;
        chk("rst_cyc",  64'(m_wb_cyc_o), 64'(0));
        chk("rst_stb",  64'(m_wb_stb_o), 64'(0));
        chk("rst_we",   64'(m_wb_we_o),  64'(0));
        chk("rst_adr",  64'(m_wb_adr_o), 64'(0));
        chk("rst_dat",  64'(m_wb_dat_o), 64'(0));
        chk("rst_done", 64'(done_o),     64'(0));
        chk("rst_err",  64'(err_o),      64'(0));
        chk("rst_resp", 64'(resp_o),     64'(0));
        chk("rst_busy", 64'(busy_o),     64'(1));
        rst = 1'b0;

        // Init sequence, with a request during init that must be dropped
        @(posedge clk); #2;
        req = 1'b1; cmd = 16'h1234; arg = 32'h5678_9ABC;
        @(posedge clk); #2;
        req = 1'b0;
        for (int c = 0; c < 100 && busy_o; c++) begin @(posedge clk); #2; end
        chk("init_busy_clear", 64'(busy_o), 64'(0));
        repeat (10) @(posedge clk); #2;
        chk("init_xfer_count", 64'(log_q.size()), 64'(2));
        got = (log_q.size() > 0) ? log_q[0] : '0;
        chk("init_timeout_wr", 64'(got), 64'({1'b1, 8'h2C, 32'h0000_777F}));
        got = (log_q.size() > 1) ? log_q[1] : '0;
        chk("init_clkdiv_wr", 64'(got), 64'({1'b1, 8'h4C, 32'h0000_0001}));
        chk("init_busy_idle", 64'(busy_o), 64'(0));
        chk("init_no_done", 64'(done_cnt), 64'(0));

        // Table-driven command scenarios
        for (int v = 0; v < 6; v++) begin
            st_q.delete();
            for (int p = 0; p < vec[v].nst; p++) st_q.push_back(vec[v].st[p]);
            r0c = vec[v].r0c;
            r38 = vec[v].r38;
            log_q.delete();
            dstart = done_cnt;
            cmd = vec[v].cmd; arg = vec[v].arg; req = 1'b1;
            @(posedge clk); #2;
            req = 1'b0; cmd = 16'hBEEF; arg = 32'hDEAD_BEEF;
            repeat (3) @(posedge clk); #2;
            req = 1'b1;
            @(posedge clk); #2;
            req = 1'b0;
            for (int c = 0; c < 400 && done_cnt == dstart; c++) begin @(posedge clk); #2; end
            repeat (8) @(posedge clk); #2;

            chk($sformatf("v%0d_done_pulses", v), 64'(done_cnt - dstart), 64'(1));
            chk($sformatf("v%0d_err", v),  64'(d_err),  64'(vec[v].exp_err));
            chk($sformatf("v%0d_resp", v), 64'(d_resp), 64'(vec[v].exp_resp));
            chk($sformatf("v%0d_err_hold", v),  64'(err_o),  64'(vec[v].exp_err));
            chk($sformatf("v%0d_resp_hold", v), 64'(resp_o), 64'(vec[v].exp_resp));
            chk($sformatf("v%0d_busy", v), 64'(busy_o), 64'(0));

            exp_q.delete();
            exp_q.push_back({1'b1, 8'h04, 16'h0, vec[v].cmd});
            exp_q.push_back({1'b1, 8'h00, vec[v].arg});
            for (int p = 0; p < vec[v].polls; p++)
                exp_q.push_back({1'b0, 8'h34, (p < vec[v].nst) ? vec[v].st[p] : 32'h0});
            if (vec[v].kind == 0) exp_q.push_back({1'b0, 8'h0C, vec[v].r0c});
            if (vec[v].kind == 1) exp_q.push_back({1'b0, 8'h38, vec[v].r38});
            exp_q.push_back({1'b1, 8'h34, 32'h0});

            chk($sformatf("v%0d_xfer_count", v), 64'(log_q.size()), 64'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (i < log_q.size()) ? log_q[i] : '0;
                chk($sformatf("v%0d_xfer%0d", v, i), 64'(got), 64'(exp_q[i]));
            end
        end

        // Reset while a status read waits for ack
        st_q.delete();
        log_q.delete();
        cmd = 16'h0042; arg = 32'h0000_0042; req = 1'b1;
        @(posedge clk); #2;
        req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk); #2;
            if (m_wb_stb_o && m_wb_adr_o == 8'h34 && !m_wb_we_o && !s_ack) found = 1'b1;
        end
        chk("mid_poll_reached", 64'(found), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_cyc",  64'(m_wb_cyc_o), 64'(0));
        chk("mid_rst_stb",  64'(m_wb_stb_o), 64'(0));
        chk("mid_rst_adr",  64'(m_wb_adr_o), 64'(0));
        chk("mid_rst_busy", 64'(busy_o),     64'(1));
        chk("mid_rst_err",  64'(err_o),      64'(0));
        chk("mid_rst_resp", 64'(resp_o),     64'(0));
        repeat (2) @(posedge clk); #2;
        log_q.delete();
        rst = 1'b0;
        for (int c = 0; c < 50 && log_q.size() == 0; c++) begin @(posedge clk); #2; end
        got = (log_q.size() > 0) ? log_q[0] : '0;
        chk("mid_rst_first_xfer", 64'(got), 64'({1'b1, 8'h2C, 32'h0000_777F}));
        for (int c = 0; c < 100 && busy_o; c++) begin @(posedge clk); #2; end
        chk("mid_rst_reinit_idle", 64'(busy_o), 64'(0));
        got = (log_q.size() > 1) ? log_q[1] : '0;
        chk("mid_rst_second_xfer", 64'(got), 64'({1'b1, 8'h4C, 32'h0000_0001}));

        chk("bus_protocol_violations", 64'(proto_err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
